// File: rtl/apb_mst_arb.sv
// Two-requester APB master: round-robin arbitration in IDLE, then a SETUP/ACCESS
// transfer with wait states, slave errors and an ACCESS-phase timeout.
module apb_mst_arb #(
    parameter int  ADDR_W  = 32,
    parameter int  DATA_W  = 32,
    parameter int  TIMEOUT = 16,
    localparam int STRB_W  = DATA_W / 8
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [1:0]            req_write,
    input  logic [2*DATA_W-1:0]   req_wdata,
    input  logic [2*STRB_W-1:0]   req_strb,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic [DATA_W-1:0]     PWDATA,
    output logic [STRB_W-1:0]     PSTRB,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    input  logic [DATA_W-1:0]     PRDATA,
    output logic [7:0]            timeout_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    localparam logic [7:0] TO_VAL = 8'(TIMEOUT);

    state_t              state_q, state_d;
    logic                prio_q, prio_d;
    logic                gnt_q, gnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   strb_q, strb_d;
    logic [7:0]          acc_cnt_q, acc_cnt_d;
    logic [1:0]          rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic [7:0]          tcnt_q, tcnt_d;

    logic [ADDR_W-1:0]   addr_arr  [2];
    logic [DATA_W-1:0]   wdata_arr [2];
    logic [STRB_W-1:0]   strb_arr  [2];
    logic                gnt_sel;
    logic                accept;

    for (genvar gi = 0; gi < 2; gi++) begin : g_req
        assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
        assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
        assign strb_arr[gi]  = req_strb[gi*STRB_W +: STRB_W];
    end

    // With both requesting the pointer decides; otherwise the lone requester wins.
    always_comb begin
        gnt_sel = 1'b0;
        if (req_valid == 2'b11) begin
            gnt_sel = prio_q;
        end else begin
            gnt_sel = req_valid[1];
        end
    end

    assign accept = (state_q == ST_IDLE) && (|req_valid) && !PRESET;

    always_comb begin
        state_d     = state_q;
        prio_d      = prio_q;
        gnt_d       = gnt_q;
        addr_d      = addr_q;
        write_d     = write_q;
        wdata_d     = wdata_q;
        strb_d      = strb_q;
        acc_cnt_d   = acc_cnt_q;
        tcnt_d      = tcnt_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
        req_ready   = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    req_ready[gnt_sel] = 1'b1;
                    gnt_d   = gnt_sel;
                    prio_d  = ~gnt_sel;
                    addr_d  = addr_arr[gnt_sel];
                    write_d = req_write[gnt_sel];
                    wdata_d = req_write[gnt_sel] ? wdata_arr[gnt_sel] : '0;
                    strb_d  = req_write[gnt_sel] ? strb_arr[gnt_sel] : '0;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                acc_cnt_d = 8'd1;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_rdata_d        = write_q ? '0 : PRDATA;
                    rsp_err_d          = PSLVERR;
                    acc_cnt_d          = 8'd0;
                    state_d            = ST_IDLE;
                end else if (acc_cnt_q == TO_VAL) begin
                    // Slave never answered: complete with an error and zero data.
                    rsp_valid_d[gnt_q] = 1'b1;
                    rsp_err_d          = 1'b1;
                    tcnt_d             = (tcnt_q == 8'hFF) ? tcnt_q : tcnt_q + 8'd1;
                    acc_cnt_d          = 8'd0;
                    state_d            = ST_IDLE;
                end else begin
                    acc_cnt_d = acc_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= ST_IDLE;
            prio_q      <= 1'b0;
            gnt_q       <= 1'b0;
            addr_q      <= '0;
            write_q     <= 1'b0;
            wdata_q     <= '0;
            strb_q      <= '0;
            acc_cnt_q   <= 8'd0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            tcnt_q      <= 8'd0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            gnt_q       <= gnt_d;
            addr_q      <= addr_d;
            write_q     <= write_d;
            wdata_q     <= wdata_d;
            strb_q      <= strb_d;
            acc_cnt_q   <= acc_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            tcnt_q      <= tcnt_d;
        end
    end

    // Bus fields are forced to zero whenever no transfer is in flight.
    assign PSEL        = (state_q != ST_IDLE);
    assign PENABLE     = (state_q == ST_ACCESS);
    assign PADDR       = PSEL ? addr_q  : '0;
    assign PWRITE      = PSEL ? write_q : 1'b0;
    assign PWDATA      = PSEL ? wdata_q : '0;
    assign PSTRB       = PSEL ? strb_q  : '0;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign timeout_cnt = tcnt_q;

endmodule
